// File: rtl/logic8_serial.sv
// Bit-serial logic unit: NOT/AND/OR/XOR over WIDTH-bit operands, one result bit per clock, LSB first.
// Optional feature: define LOGIC8_SERIAL_PARITY_EN to drive parity with the XOR-reduction of result.
module logic8_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             bit_res;

  always_comb begin
    bit_res = 1'b0;
    unique case (op_q)
      2'b00:   bit_res = ~a_q[cnt_q];
      2'b01:   bit_res = a_q[cnt_q] & b_q[cnt_q];
      2'b10:   bit_res = a_q[cnt_q] | b_q[cnt_q];
      2'b11:   bit_res = a_q[cnt_q] ^ b_q[cnt_q];
      default: bit_res = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    shift_d  = shift_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Right shift: after WIDTH bits, bit 0 has travelled from the MSB down to position 0.
        shift_d = {bit_res, shift_q[WIDTH-1:1]};
        if (cnt_q == CntLast) begin
          cnt_d    = '0;
          result_d = shift_d;
          zero_d   = ~|shift_d;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shift_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

`ifdef LOGIC8_SERIAL_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (done_d) begin
      parity_d = ^shift_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign busy   = (state_q == StShift);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule
